// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the dual-channel PWM duty scheduler.
// Optional feature macro used by the scheduler files: ESTOP_EN (adds the estop input).
package pwm_ctrl_pkg;

    localparam int unsigned DUTY_W  = 8;
    localparam int unsigned NUM_CH  = 2;
    localparam logic [7:0]  CNT_MAX = 8'hFF;

    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_e;

    // Move cur toward tgt by at most step; 9-bit math so it never wraps or overshoots.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] diff;
        logic [DUTY_W:0] amt;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            amt  = (diff < {1'b0, step}) ? diff : {1'b0, step};
            return DUTY_W'({1'b0, cur} + amt);
        end else if (tgt < cur) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            amt  = (diff < {1'b0, step}) ? diff : {1'b0, step};
            return DUTY_W'({1'b0, cur} - amt);
        end
        return cur;
    endfunction

    // Ramp direction needed to get from cur to tgt.
    function automatic ramp_state_e dir_of(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        if (tgt > cur) begin
            return UP;
        end else if (tgt < cur) begin
            return DOWN;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/pwm_ramp_chan.sv
// One PWM channel: pending-command slot, target register, ramp FSM and done pulse.
// Optional feature macro: ESTOP_EN (adds estop, which forces the channel to duty 0).
module pwm_ramp_chan
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ESTOP_EN
    input  logic              estop,
`endif
    input  logic              tick,
    input  logic              step_en,
    input  logic              acc,
    input  logic [DUTY_W-1:0] acc_duty,
    input  logic              acc_imm,
    output logic              pend,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    localparam logic [DUTY_W-1:0] STEP_L = DUTY_W'(STEP);

    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] pend_tgt;
    logic              pend_imm;
    ramp_state_e       state;

    logic              load;
    logic              load_imm;
    logic [DUTY_W-1:0] eff_tgt;
    logic [DUTY_W-1:0] stepped;

    // Target seen this cycle: a pending command takes effect on the tick itself.
    always_comb begin
        load     = tick && pend;
        load_imm = load && pend_imm;
        eff_tgt  = load ? pend_tgt : tgt;
        stepped  = step_toward(duty, eff_tgt, STEP_L);
    end

    // Pending slot, target load, ramp FSM and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt      <= '0;
            pend_tgt <= '0;
            pend_imm <= 1'b0;
            pend     <= 1'b0;
            duty     <= '0;
            state    <= IDLE;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
`ifdef ESTOP_EN
            if (estop) begin
                tgt      <= '0;
                pend     <= 1'b0;
                pend_imm <= 1'b0;
                duty     <= '0;
                state    <= IDLE;
            end else
`endif
            begin
                if (load) begin
                    pend <= 1'b0;
                    tgt  <= pend_tgt;
                end

                if (load_imm) begin
                    duty  <= pend_tgt;
                    state <= IDLE;
                    done  <= (duty != pend_tgt);
                end else if (step_en && (duty != eff_tgt)) begin
                    duty  <= stepped;
                    state <= dir_of(stepped, eff_tgt);
                    done  <= (stepped == eff_tgt);
                end else if (load) begin
                    // New target without a step this tick; equal target lands in IDLE silently.
                    state <= dir_of(duty, eff_tgt);
                end

                // Accept only happens while the slot is empty, so it never races the clear.
                if (acc) begin
                    pend     <= 1'b1;
                    pend_tgt <= acc_duty;
                    pend_imm <= acc_imm;
                end
            end
        end
    end

    assign busy = pend || (state != IDLE);

endmodule

// File: rtl/pwm_ramp_sched.sv
// Duty scheduler for the A/B PWM pair: period counter, ramp divider, command mux.
// Optional feature macro: ESTOP_EN (adds estop input forcing both duties to 0).
module pwm_ramp_sched
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned STEP     = 1,
    parameter int unsigned RAMP_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ESTOP_EN
    input  logic              estop,
`endif
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_ch,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_imm,
    output logic [DUTY_W-1:0] duty_a,
    output logic [DUTY_W-1:0] duty_b,
    output logic              prd_tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);
    localparam logic [7:0] CNT_PRE  = CNT_MAX - 8'd1;

    logic [7:0]        cnt;
    logic [7:0]        div;
    logic              step_en;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] acc;

    // Free-running period counter; prd_tick is registered so it is high exactly while cnt==FF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_tick <= 1'b0;
        end else begin
            cnt      <= cnt + 8'd1;
            prd_tick <= (cnt == CNT_PRE);
        end
    end

    // Ramp divider shared by both channels, advanced once per period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (prd_tick) begin
            div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
        end
    end

    assign step_en = prd_tick && (div == DIV_LAST);

    // Ready follows the addressed channel's pending slot; accept is steered to that channel.
    always_comb begin
        cmd_rdy = !pend[cmd_ch];
`ifdef ESTOP_EN
        if (estop) begin
            cmd_rdy = 1'b0;
        end
`endif
        acc       = '0;
        acc[CH_A] = cmd_vld && cmd_rdy && (cmd_ch == 1'(CH_A));
        acc[CH_B] = cmd_vld && cmd_rdy && (cmd_ch == 1'(CH_B));
    end

    pwm_ramp_chan #(
        .STEP     (STEP)
    ) u_chan_a (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ESTOP_EN
        .estop    (estop),
`endif
        .tick     (prd_tick),
        .step_en  (step_en),
        .acc      (acc[CH_A]),
        .acc_duty (cmd_duty),
        .acc_imm  (cmd_imm),
        .pend     (pend[CH_A]),
        .duty     (duty_a),
        .busy     (busy[CH_A]),
        .done     (done[CH_A])
    );

    pwm_ramp_chan #(
        .STEP     (STEP)
    ) u_chan_b (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ESTOP_EN
        .estop    (estop),
`endif
        .tick     (prd_tick),
        .step_en  (step_en),
        .acc      (acc[CH_B]),
        .acc_duty (cmd_duty),
        .acc_imm  (cmd_imm),
        .pend     (pend[CH_B]),
        .duty     (duty_b),
        .busy     (busy[CH_B]),
        .done     (done[CH_B])
    );

endmodule

// File: doc/pwm_ramp_sched.md
Name: pwm_ramp_sched

Overview:
- Duty-cycle scheduler for the dual 8-bit PWM channel pair (A, B).
- Takes target-duty commands over a valid/ready handshake.
- Ramps each channel's applied duty toward its target at a programmable slew.
- Changes the applied duty only at the PWM period boundary, so a compare match is never missed mid-period.
- Sits between the control/command logic and the two 8-bit PWM generators, driving their duty inputs.

Parameters:
- STEP, 1: duty LSBs moved per ramp step (1..255).
- RAMP_DIV, 1: PWM periods per ramp step (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready (combinational from cmd_ch and pend state)
- cmd_ch  in  1  target channel: 0=A, 1=B
- cmd_duty  in  8  target duty
- cmd_imm  in  1  apply target immediately at next boundary, no ramp
- duty_a  out  8  applied duty, channel A
- duty_b  out  8  applied duty, channel B
- prd_tick  out  1  high for the cycle where the period counter is 8'hFF
- busy  out  2  per channel: pending command or ramp in progress
- done  out  2  one-cycle pulse when a channel's duty reaches its target

Behaviour:
- Reset values:
  - Period counter 0, divider counter 0.
  - duty_a=duty_b=0, targets 0, pend=0, imm flags 0.
  - FSMs IDLE, prd_tick=0, busy=0, done=0.
- Period counter:
  - 8-bit, free-running, wraps 8'hFF to 0; reset together with the PWM generators so the two stay aligned.
  - Tick = (cnt==8'hFF). A duty written on a tick is seen by the PWM from count 0 onward.
- Ramp divider:
  - Counts ticks 0..RAMP_DIV-1; step_en = tick && div==RAMP_DIV-1.
  - Shared by both channels.
- Handshake:
  - cmd_rdy = !pend[cmd_ch]; transfer on cmd_vld && cmd_rdy.
  - Transfer latches cmd_duty to pend_tgt[ch] and cmd_imm to pend_imm[ch], and sets pend[ch].
  - At most one pending command per channel; the other channel is unaffected.
- On a tick with pend[ch]=1:
  - tgt[ch] <= pend_tgt[ch]; pend clears.
  - If pend_imm: duty <= target, FSM goes to IDLE, done pulses if the duty changed.
  - Otherwise, if step_en in the same cycle, the step is taken toward the new target.
- Per-channel FSM, evaluated on step_en:
  - IDLE: duty==tgt. On a new target, go to UP if tgt>duty, DOWN if tgt<duty.
  - UP: duty <= duty + min(STEP, tgt-duty).
  - DOWN: duty <= duty - min(STEP, duty-tgt).
  - Computed in 9 bits; never overshoots, never wraps.
  - On reaching tgt: go to IDLE and pulse done[ch] on the next cycle.
- Retarget mid-ramp:
  - The new target loads at the next tick.
  - Direction is re-evaluated from the current duty; it may reverse.
  - New target equal to the current duty: go to IDLE, no done pulse.
- Simultaneous accept and tick on the same channel: the tick sees the old pend=0, so the new command applies at the following tick (one-period latency, by design).
- busy[ch] = pend[ch] || state!=IDLE.
- Reset mid-ramp: all state returns to reset values immediately; pending commands are discarded.

Optional Feature:
- Macro ESTOP_EN. Adds input estop (1 bit, synchronous, active-high).
- When estop is high:
  - duty_a and duty_b are forced to 0 on the next clk edge, not waiting for the tick.
  - tgt and pend are cleared and FSMs go to IDLE.
  - cmd_rdy is held low.
  - No done pulses are generated.
- When estop deasserts: normal operation resumes from duty 0.
- Without ESTOP_EN: the port is absent and the logic is not built.

Decomposition:
- Package pwm_ctrl_pkg:
  - DUTY_W=8, CNT_MAX=8'hFF.
  - Channel constants CH_A=0, CH_B=1.
  - Ramp state typedef {IDLE, UP, DOWN}.
- Sub-module pwm_ramp_chan, instantiated twice:
  - Per-channel pend/target registers, FSM, saturating step and done pulse.
- The top level owns the period counter, ramp divider and handshake mux.

Test Plan:
- Basic ramp up, STEP=1, RAMP_DIV=1, from reset:
  - Stimulus: A cmd duty=4 accepted at cycle 10.
  - Response: duty_a goes 1,2,3,4 from cycles 256, 512, 768, 1024; done[0] pulses once; busy[0] falls.
- Saturating down-step, STEP=3:
  - Stimulus: A at 10, cmd duty=5.
  - Response: duty_a goes 7 then 5; no underflow past 5.
- Immediate apply:
  - Stimulus: B cmd duty=200, imm=1.
  - Response: duty_b=200 at the first tick after accept; duty_a unchanged.
- Backpressure:
  - Stimulus: second A cmd before the first is applied.
  - Response: cmd_rdy low for ch A and high for ch B; the A command transfers right after the tick.
- Accept on the tick cycle:
  - Stimulus: A cmd accepted exactly when cnt==8'hFF.
  - Response: target applied one period later.
- Reset mid-ramp (and estop under ESTOP_EN):
  - Stimulus: reset asserted while ramping.
  - Response: outputs reset to 0 and cmd_rdy high on release.
